calc_sequencer: RTL and testbench
=================================

// Module: calc_sequencer
// PURPOSE
//  Control FSM for the 4-digit keypad calculator. Takes debounced key events from keypad.
//  Builds operands A and B in binary from decimal digit entry and latches the operator.
//  Runs one external multi-cycle ALU (calc_alu_iter) with a start/done handshake.
//  Drives the value and sign shown on HEX0-3 (through bin2bcd + bin2ssd) and the error LED.
// PARAMETERS
//  W           14    operand/result magnitude width; must hold MAX_VAL
//  MAX_DIGITS  4     max decimal digits accepted per operand
//  MAX_VAL     9999  largest displayable magnitude; above this -> error
//  ALU_TMO     255   cycles to wait for alu_done before error
// PORTS
//  clk          in   1     system clock (CLOCK_50)
//  reset        in   1     synchronous, active-high reset
//  key_valid    in   1     one-cycle pulse per key release
//  key_is_oper  in   1     1: key_code is an operator; 0: key_code is a digit 0-9
//  key_code     in   4     digit value or OP_* code
//  alu_start    out  1     one-cycle pulse; alu_op/a/b/a_neg must be stable while alu_busy
//  alu_op       out  2     ALU_ADD/SUB/MUL/DIV
//  alu_a        out  W     A magnitude
//  alu_a_neg    out  1     A sign
//  alu_b        out  W     B magnitude (B is never negative)
//  alu_done     in   1     one-cycle pulse; result valid in the same cycle
//  alu_result   in   2W    result magnitude
//  alu_res_neg  in   1     result sign
//  alu_div0     in   1     divide-by-zero flag, qualified by alu_done
//  alu_busy     out  1     high from alu_start until alu_done
//  disp_val     out  W     magnitude to display
//  disp_neg     out  1     minus sign to display
//  error        out  1     sticky error indicator
//  op_latched   out  4     pending operator, for LEDG
// BEHAVIOUR
//  Reset: all outputs 0; A=B=0; digit count 0; state ENTER_A.
//  Any key_valid in reset cycle is ignored.
//  Digit entry:
//   - value <= value*10 + digit, count += 1, only while count < MAX_DIGITS; extra digits dropped.
//   - Digit 0 while value==0 is dropped: count stays 0, so no leading zeros.
//  States:
//   ENTER_A:
//    - digit -> update A, disp_val=A.
//    - ADD/SUB/MUL/DIV -> op_latched=op, go OP_WAIT.
//    - EQ ignored.
//   OP_WAIT:
//    - digit -> B=digit (0 allowed, count=1), go ENTER_B.
//    - operator -> replace op_latched.
//    - EQ ignored.
//   ENTER_B:
//    - digit -> update B, disp_val=B, disp_neg=0.
//    - EQ or operator -> go EXEC; for an operator, it is held as pend_op.
//   EXEC: assert alu_start for 1 cycle, go WAIT_ALU. Latency from key to alu_start is 1 cycle.
//   WAIT_ALU: all keys except CLR ignored. On alu_done:
//    - alu_div0, or alu_result > MAX_VAL -> error=1, disp_val=0, go ERR.
//    - else A=result, a_neg=res_neg, disp shows A; A is now the chain operand.
//      If pend_op is set -> op_latched=pend_op, go OP_WAIT; else go SHOW.
//    - Timeout: ALU_TMO cycles with no done -> error=1, go ERR.
//   SHOW:
//    - digit -> start a new A (A=digit, a_neg=0), go ENTER_A.
//    - operator -> chain, go OP_WAIT.
//    - EQ -> repeat the last op with the same B, go EXEC.
//   ERR: only CLR is accepted.
//  CLR (OP_CLR):
//   - From any state except WAIT_ALU: A=B=0, signs 0, error=0, op_latched=0, go ENTER_A, same cycle.
//   - In WAIT_ALU: clear the registers, go DRAIN. DRAIN discards the next alu_done (or waits out the
//     timeout), then goes to ENTER_A. alu_start is never asserted while alu_busy.
//  Width: digit accumulate uses W+4 bits; it cannot overflow at MAX_DIGITS=4.
//  alu_result upper W bits nonzero -> overflow error.
//  Simultaneous key_valid and alu_done in WAIT_ALU: done is processed, key is dropped (CLR excepted).
//  reset mid-ALU: FSM returns to ENTER_A; a stray alu_done after reset is ignored (no ALU ownership).
// STRUCTURE
//  calc_pkg:
//   - OP_ADD=1, OP_SUB=2, OP_MUL=3, OP_DIV=4, OP_CLR=5, OP_EQ=6.
//   - ALU_ADD=0, ALU_SUB=1, ALU_MUL=2, ALU_DIV=3.
//   - State encodings: ENTER_A, OP_WAIT, ENTER_B, EXEC, WAIT_ALU, SHOW, ERR, DRAIN.
//   - Function op2alu.
//  Sub-module: calc_digit_acc (x10+digit accumulator with count and leading-zero rule). Instantiated
//  once; it is muxed between A and B by state. calc_alu_iter stays external.
// TESTING
//  1. Keys 1,2,3,ADD,4,5,EQ; ALU model has 5-cycle latency -> one alu_start, op=ADD, a=123, b=45;
//     disp_val=168, state SHOW.
//  2. Keys 5,SUB,8,EQ, ALU returns 3 neg -> disp_val=3, disp_neg=1; then MUL,2,EQ -> alu_a=3,
//     alu_a_neg=1, b=2; result -6.
//  3. Keys 9,9,9,9,9 -> A=9999 (5th digit dropped). Then MUL,2,EQ -> result 19998 -> error=1.
//     Digit keys ignored; CLR -> error=0, disp_val=0.
//  4. Keys 0,0,7 -> A=7, count 1. Then DIV,0,EQ with alu_div0 -> error=1. Then 8,DIV,2,EQ,EQ ->
//     displays 4, then 2.
//  5. CLR pressed two cycles after alu_start, alu_done 3 cycles later -> no display update, no second
//     alu_start, state ENTER_A.
//  6. Chain 2,ADD,3,MUL (no EQ) -> alu ADD runs, disp 5, op_latched=MUL; then 4,EQ -> 20.
//     ALU never responds -> error after ALU_TMO cycles.

Source files
------------

// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Key codes, ALU op codes, sequencer states and helpers for
//                the keypad calculator.
//  Revision    : 1.0  initial release
// ============================================================================
package calc_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_CLR  = 4'd5;
    localparam logic [3:0] OP_EQ   = 4'd6;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_MUL = 2'd2;
    localparam logic [1:0] ALU_DIV = 2'd3;

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        OP_WAIT  = 3'd1,
        ENTER_B  = 3'd2,
        EXEC     = 3'd3,
        WAIT_ALU = 3'd4,
        SHOW     = 3'd5,
        ERR      = 3'd6,
        DRAIN    = 3'd7
    } state_t;

    function automatic logic [1:0] op2alu(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic is_arith(input logic [3:0] code);
        return (code >= OP_ADD) && (code <= OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/calc_digit_acc.sv
`default_nettype none
// ============================================================================
//  Module      : calc_digit_acc
//  Description : Decimal digit accumulator (value*10 + digit) with a digit
//                limit and leading-zero suppression. Purely combinational.
//  Revision    : 1.0  initial release
// ============================================================================
module calc_digit_acc
    import calc_pkg::*;
#(
    parameter int W          = 14,
    parameter int MAX_DIGITS = 4,
    parameter int CW         = 3
)(
    input  logic [W-1:0]  i_cur_val,
    input  logic [CW-1:0] i_cur_cnt,
    input  logic [3:0]    i_digit,
    output logic [W-1:0]  o_nxt_val,
    output logic [CW-1:0] o_nxt_cnt
);

    localparam int c_ACC_W = W + 4;

    logic w_room;
    logic w_lead_zero;

    assign w_room      = (i_cur_cnt < CW'(MAX_DIGITS));
    assign w_lead_zero = (i_cur_val == '0) && (i_digit == 4'd0);

    // Wide intermediate keeps the multiply exact before narrowing back to W.
    always_comb begin
        o_nxt_val = i_cur_val;
        o_nxt_cnt = i_cur_cnt;
        if (w_room && !w_lead_zero) begin
            o_nxt_val = W'((c_ACC_W'(i_cur_val) * c_ACC_W'(10)) + c_ACC_W'(i_digit));
            o_nxt_cnt = i_cur_cnt + CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : calc_sequencer
//  Description : Control FSM of the keypad calculator: operand entry, operator
//                latching, ALU start/done handshake, display and error LED.
//  Revision    : 1.0  initial release
// ============================================================================
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int W          = 14,
    parameter int MAX_DIGITS = 4,
    parameter int MAX_VAL    = 9999,
    parameter int ALU_TMO    = 255
)(
    input  logic           clk,
    input  logic           reset,
    input  logic           key_valid,
    input  logic           key_is_oper,
    input  logic [3:0]     key_code,
    output logic           alu_start,
    output logic [1:0]     alu_op,
    output logic [W-1:0]   alu_a,
    output logic           alu_a_neg,
    output logic [W-1:0]   alu_b,
    input  logic           alu_done,
    input  logic [2*W-1:0] alu_result,
    input  logic           alu_res_neg,
    input  logic           alu_div0,
    output logic           alu_busy,
    output logic [W-1:0]   disp_val,
    output logic           disp_neg,
    output logic           error,
    output logic [3:0]     op_latched
);

    localparam int c_CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int c_TMO_W = $clog2(ALU_TMO + 1);

    state_t               r_state, w_state_nxt;
    logic [W-1:0]         r_a, w_a_nxt;
    logic                 r_a_neg, w_a_neg_nxt;
    logic [W-1:0]         r_b, w_b_nxt;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [3:0]           r_op, w_op_nxt;
    logic [3:0]           r_pend, w_pend_nxt;
    logic [W-1:0]         r_disp_val, w_disp_val_nxt;
    logic                 r_disp_neg, w_disp_neg_nxt;
    logic                 r_error, w_error_nxt;
    logic [c_TMO_W-1:0]   r_tmo, w_tmo_nxt;
    logic [1:0]           r_alu_op, w_alu_op_nxt;
    logic [W-1:0]         r_alu_a, w_alu_a_nxt;
    logic                 r_alu_a_neg, w_alu_a_neg_nxt;
    logic [W-1:0]         r_alu_b, w_alu_b_nxt;

    logic                 w_key_dig, w_key_arith, w_key_eq, w_key_clr;
    logic                 w_tmo_hit, w_res_bad;
    logic [W-1:0]         w_acc_val_in, w_acc_val;
    logic [c_CNT_W-1:0]   w_acc_cnt_in, w_acc_cnt;

    assign w_key_dig   = key_valid && !key_is_oper && (key_code <= 4'd9);
    assign w_key_arith = key_valid && key_is_oper && is_arith(key_code);
    assign w_key_eq    = key_valid && key_is_oper && (key_code == OP_EQ);
    assign w_key_clr   = key_valid && key_is_oper && (key_code == OP_CLR);
    assign w_tmo_hit   = (r_tmo == c_TMO_W'(ALU_TMO - 1));
    assign w_res_bad   = alu_div0 || (alu_result > (2*W)'(MAX_VAL));

    // One accumulator serves both operands; SHOW starts a fresh A from zero.
    assign w_acc_val_in = (r_state == ENTER_B) ? r_b :
                          (r_state == SHOW)    ? '0  : r_a;
    assign w_acc_cnt_in = (r_state == ENTER_B || r_state == ENTER_A) ? r_cnt : '0;

    calc_digit_acc #(
        .W          (W),
        .MAX_DIGITS (MAX_DIGITS),
        .CW         (c_CNT_W)
    ) u_digit_acc (
        .i_cur_val (w_acc_val_in),
        .i_cur_cnt (w_acc_cnt_in),
        .i_digit   (key_code),
        .o_nxt_val (w_acc_val),
        .o_nxt_cnt (w_acc_cnt)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_a_nxt         = r_a;
        w_a_neg_nxt     = r_a_neg;
        w_b_nxt         = r_b;
        w_cnt_nxt       = r_cnt;
        w_op_nxt        = r_op;
        w_pend_nxt      = r_pend;
        w_disp_val_nxt  = r_disp_val;
        w_disp_neg_nxt  = r_disp_neg;
        w_error_nxt     = r_error;
        w_tmo_nxt       = r_tmo;
        w_alu_op_nxt    = r_alu_op;
        w_alu_a_nxt     = r_alu_a;
        w_alu_a_neg_nxt = r_alu_a_neg;
        w_alu_b_nxt     = r_alu_b;

        case (r_state)
            ENTER_A: begin
                if (w_key_dig) begin
                    w_a_nxt        = w_acc_val;
                    w_cnt_nxt      = w_acc_cnt;
                    w_disp_val_nxt = w_acc_val;
                    w_disp_neg_nxt = 1'b0;
                end else if (w_key_arith) begin
                    w_op_nxt    = key_code;
                    w_state_nxt = OP_WAIT;
                end
            end
            OP_WAIT: begin
                if (w_key_dig) begin
                    w_b_nxt        = W'(key_code);
                    w_cnt_nxt      = c_CNT_W'(1);
                    w_disp_val_nxt = W'(key_code);
                    w_disp_neg_nxt = 1'b0;
                    w_state_nxt    = ENTER_B;
                end else if (w_key_arith) begin
                    w_op_nxt = key_code;
                end
            end
            ENTER_B: begin
                if (w_key_dig) begin
                    w_b_nxt        = w_acc_val;
                    w_cnt_nxt      = w_acc_cnt;
                    w_disp_val_nxt = w_acc_val;
                    w_disp_neg_nxt = 1'b0;
                end else if (w_key_eq) begin
                    w_pend_nxt  = OP_NONE;
                    w_state_nxt = EXEC;
                end else if (w_key_arith) begin
                    w_pend_nxt  = key_code;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_tmo_nxt   = '0;
                w_state_nxt = WAIT_ALU;
            end
            WAIT_ALU: begin
                if (alu_done) begin
                    if (w_res_bad) begin
                        w_error_nxt    = 1'b1;
                        w_disp_val_nxt = '0;
                        w_disp_neg_nxt = 1'b0;
                        w_state_nxt    = ERR;
                    end else begin
                        w_a_nxt        = alu_result[W-1:0];
                        w_a_neg_nxt    = alu_res_neg;
                        w_disp_val_nxt = alu_result[W-1:0];
                        w_disp_neg_nxt = alu_res_neg;
                        if (r_pend != OP_NONE) begin
                            w_op_nxt    = r_pend;
                            w_pend_nxt  = OP_NONE;
                            w_state_nxt = OP_WAIT;
                        end else begin
                            w_state_nxt = SHOW;
                        end
                    end
                end else if (w_tmo_hit) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = ERR;
                end else begin
                    w_tmo_nxt = r_tmo + c_TMO_W'(1);
                end
            end
            SHOW: begin
                if (w_key_dig) begin
                    w_a_nxt        = w_acc_val;
                    w_a_neg_nxt    = 1'b0;
                    w_cnt_nxt      = w_acc_cnt;
                    w_disp_val_nxt = w_acc_val;
                    w_disp_neg_nxt = 1'b0;
                    w_state_nxt    = ENTER_A;
                end else if (w_key_arith) begin
                    w_op_nxt    = key_code;
                    w_state_nxt = OP_WAIT;
                end else if (w_key_eq) begin
                    w_pend_nxt  = OP_NONE;
                    w_state_nxt = EXEC;
                end
            end
            ERR: begin
                w_state_nxt = ERR;
            end
            DRAIN: begin
                if (alu_done || w_tmo_hit) begin
                    w_state_nxt = ENTER_A;
                end else begin
                    w_tmo_nxt = r_tmo + c_TMO_W'(1);
                end
            end
            default: w_state_nxt = ENTER_A;
        endcase

        // While the ALU is owned, CLR must still wait for (or time out) its done.
        if (w_key_clr) begin
            w_a_nxt        = '0;
            w_a_neg_nxt    = 1'b0;
            w_b_nxt        = '0;
            w_cnt_nxt      = '0;
            w_op_nxt       = OP_NONE;
            w_pend_nxt     = OP_NONE;
            w_disp_val_nxt = '0;
            w_disp_neg_nxt = 1'b0;
            w_error_nxt    = 1'b0;
            if (r_state == EXEC) begin
                w_state_nxt = DRAIN;
            end else if (r_state == WAIT_ALU) begin
                w_state_nxt = (alu_done || w_tmo_hit) ? ENTER_A : DRAIN;
            end else if (r_state != DRAIN) begin
                w_state_nxt = ENTER_A;
            end
        end

        if (w_state_nxt == EXEC) begin
            w_alu_op_nxt    = op2alu(r_op);
            w_alu_a_nxt     = r_a;
            w_alu_a_neg_nxt = r_a_neg;
            w_alu_b_nxt     = r_b;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ENTER_A;
            r_a         <= '0;
            r_a_neg     <= 1'b0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_op        <= OP_NONE;
            r_pend      <= OP_NONE;
            r_disp_val  <= '0;
            r_disp_neg  <= 1'b0;
            r_error     <= 1'b0;
            r_tmo       <= '0;
            r_alu_op    <= ALU_ADD;
            r_alu_a     <= '0;
            r_alu_a_neg <= 1'b0;
            r_alu_b     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_a_neg     <= w_a_neg_nxt;
            r_b         <= w_b_nxt;
            r_cnt       <= w_cnt_nxt;
            r_op        <= w_op_nxt;
            r_pend      <= w_pend_nxt;
            r_disp_val  <= w_disp_val_nxt;
            r_disp_neg  <= w_disp_neg_nxt;
            r_error     <= w_error_nxt;
            r_tmo       <= w_tmo_nxt;
            r_alu_op    <= w_alu_op_nxt;
            r_alu_a     <= w_alu_a_nxt;
            r_alu_a_neg <= w_alu_a_neg_nxt;
            r_alu_b     <= w_alu_b_nxt;
        end
    end

    assign alu_start  = (r_state == EXEC);
    assign alu_busy   = (r_state == EXEC) || (r_state == WAIT_ALU) || (r_state == DRAIN);
    assign alu_op     = r_alu_op;
    assign alu_a      = r_alu_a;
    assign alu_a_neg  = r_alu_a_neg;
    assign alu_b      = r_alu_b;
    assign disp_val   = r_disp_val;
    assign disp_neg   = r_disp_neg;
    assign error      = r_error;
    assign op_latched = r_op;

endmodule
`default_nettype wire

// File: tb/tb_calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_sequencer
//  Description : Self-checking bench for calc_sequencer with a behavioural
//                signed ALU model of configurable latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_calc_sequencer;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid, key_is_oper;
    logic [3:0]  key_code;
    logic        alu_start, alu_a_neg, alu_busy;
    logic [1:0]  alu_op;
    logic [13:0] alu_a, alu_b, disp_val;
    logic        disp_neg, error;
    logic [3:0]  op_latched;

    logic        m_done = 1'b0, m_res_neg = 1'b0, m_div0 = 1'b0;
    logic [27:0] m_res = '0;
    logic        m_act = 1'b0, m_respond = 1'b1;
    int          m_cnt = 0, m_lat = 5, m_starts = 0, m_overlap = 0;
    logic [13:0] m_a = '0, m_b = '0;
    logic        m_a_neg = 1'b0;
    logic [1:0]  m_op = '0;

    int n_checks = 0;
    int n_fail   = 0;

    calc_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_is_oper (key_is_oper),
        .key_code    (key_code),
        .alu_start   (alu_start),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_a_neg   (alu_a_neg),
        .alu_b       (alu_b),
        .alu_done    (m_done),
        .alu_result  (m_res),
        .alu_res_neg (m_res_neg),
        .alu_div0    (m_div0),
        .alu_busy    (alu_busy),
        .disp_val    (disp_val),
        .disp_neg    (disp_neg),
        .error       (error),
        .op_latched  (op_latched)
    );

    always #5 clk = ~clk;

    // Signed reference arithmetic: returns {negative, magnitude}.
    function automatic logic [28:0] model_calc(input logic [1:0] op, input logic [13:0] a,
                                               input logic an, input logic [13:0] b);
        longint sa, sb, r;
        sa = a;
        if (an) sa = -sa;
        sb = b;
        case (op)
            2'd0:    r = sa + sb;
            2'd1:    r = sa - sb;
            2'd2:    r = sa * sb;
            default: r = (sb == 0) ? 0 : sa / sb;
        endcase
        if (r < 0) return {1'b1, 28'(-r)};
        return {1'b0, 28'(r)};
    endfunction

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (alu_start) begin
            if (m_act) m_overlap <= m_overlap + 1;
            m_starts  <= m_starts + 1;
            m_a       <= alu_a;
            m_a_neg   <= alu_a_neg;
            m_b       <= alu_b;
            m_op      <= alu_op;
            {m_res_neg, m_res} <= model_calc(alu_op, alu_a, alu_a_neg, alu_b);
            m_div0    <= (alu_op == 2'd3) && (alu_b == 14'd0);
            m_act     <= 1'b1;
            m_cnt     <= m_lat;
        end else if (m_act) begin
            if (m_cnt <= 1) begin
                m_act  <= 1'b0;
                m_done <= m_respond;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    typedef struct {
        logic        is_op;
        logic [3:0]  code;
        logic [13:0] exp_val;
        logic        exp_neg;
        logic        exp_err;
        logic [3:0]  exp_op;
    } vec_t;

    vec_t vecs[$];

    task automatic add_v(input logic op, input logic [3:0] code, input int val,
                         input logic neg, input logic err, input logic [3:0] opl);
        vec_t v;
        v.is_op = op; v.code = code; v.exp_val = 14'(val);
        v.exp_neg = neg; v.exp_err = err; v.exp_op = opl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    task automatic press(input logic op, input logic [3:0] code);
        @(negedge clk);
        key_valid = 1'b1; key_is_oper = op; key_code = code;
        @(negedge clk);
        key_valid = 1'b0; key_is_oper = 1'b0; key_code = 4'd0;
    endtask

    task automatic settle();
        int n = 0;
        while (alu_busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("alu_settle", n, alu_busy, 0);
        @(negedge clk);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            press(vecs[i].is_op, vecs[i].code);
            settle();
            chk("disp_val",   i, disp_val,   vecs[i].exp_val);
            chk("disp_neg",   i, disp_neg,   vecs[i].exp_neg);
            chk("error",      i, error,      vecs[i].exp_err);
            chk("op_latched", i, op_latched, vecs[i].exp_op);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int t1_end, t2_end, s0, n;

        // Case 1
        add_v(0, 4'd1, 1, 0, 0, OP_NONE);
        add_v(0, 4'd2, 12, 0, 0, OP_NONE);
        add_v(0, 4'd3, 123, 0, 0, OP_NONE);
        add_v(1, OP_ADD, 123, 0, 0, OP_ADD);
        add_v(0, 4'd4, 4, 0, 0, OP_ADD);
        add_v(0, 4'd5, 45, 0, 0, OP_ADD);
        add_v(1, OP_EQ, 168, 0, 0, OP_ADD);
        t1_end = vecs.size();
        // Case 2 (EQ in ENTER_A ignored)
        add_v(1, OP_CLR, 0, 0, 0, OP_NONE);
        add_v(0, 4'd5, 5, 0, 0, OP_NONE);
        add_v(1, OP_EQ, 5, 0, 0, OP_NONE);
        add_v(1, OP_SUB, 5, 0, 0, OP_SUB);
        add_v(0, 4'd8, 8, 0, 0, OP_SUB);
        add_v(1, OP_EQ, 3, 1, 0, OP_SUB);
        add_v(1, OP_MUL, 3, 1, 0, OP_MUL);
        add_v(0, 4'd2, 2, 0, 0, OP_MUL);
        add_v(1, OP_EQ, 6, 1, 0, OP_MUL);
        t2_end = vecs.size();
        // Case 3
        add_v(1, OP_CLR, 0, 0, 0, OP_NONE);
        add_v(0, 4'd9, 9, 0, 0, OP_NONE);
        add_v(0, 4'd9, 99, 0, 0, OP_NONE);
        add_v(0, 4'd9, 999, 0, 0, OP_NONE);
        add_v(0, 4'd9, 9999, 0, 0, OP_NONE);
        add_v(0, 4'd9, 9999, 0, 0, OP_NONE);
        add_v(1, OP_MUL, 9999, 0, 0, OP_MUL);
        add_v(0, 4'd2, 2, 0, 0, OP_MUL);
        add_v(1, OP_EQ, 0, 0, 1, OP_MUL);
        add_v(0, 4'd5, 0, 0, 1, OP_MUL);
        add_v(1, OP_ADD, 0, 0, 1, OP_MUL);
        add_v(1, OP_CLR, 0, 0, 0, OP_NONE);
        // Case 4
        add_v(0, 4'd0, 0, 0, 0, OP_NONE);
        add_v(0, 4'd0, 0, 0, 0, OP_NONE);
        add_v(0, 4'd7, 7, 0, 0, OP_NONE);
        add_v(0, 4'd1, 71, 0, 0, OP_NONE);
        add_v(0, 4'd2, 712, 0, 0, OP_NONE);
        add_v(0, 4'd3, 7123, 0, 0, OP_NONE);
        add_v(0, 4'd4, 7123, 0, 0, OP_NONE);
        add_v(1, OP_DIV, 7123, 0, 0, OP_DIV);
        add_v(0, 4'd0, 0, 0, 0, OP_DIV);
        add_v(1, OP_EQ, 0, 0, 1, OP_DIV);
        add_v(1, OP_CLR, 0, 0, 0, OP_NONE);
        add_v(0, 4'd8, 8, 0, 0, OP_NONE);
        add_v(1, OP_ADD, 8, 0, 0, OP_ADD);
        add_v(1, OP_DIV, 8, 0, 0, OP_DIV);
        add_v(1, OP_EQ, 8, 0, 0, OP_DIV);
        add_v(0, 4'd2, 2, 0, 0, OP_DIV);
        add_v(1, OP_EQ, 4, 0, 0, OP_DIV);
        add_v(1, OP_EQ, 2, 0, 0, OP_DIV);

        // Reset, with a key pulse that must be ignored.
        reset = 1'b1; key_valid = 1'b1; key_is_oper = 1'b0; key_code = 4'd7;
        repeat (3) @(negedge clk);
        key_valid = 1'b0; key_code = 4'd0;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_disp_val", 0, disp_val, 0);
        chk("rst_disp_neg", 0, disp_neg, 0);
        chk("rst_error", 0, error, 0);
        chk("rst_op", 0, op_latched, 0);
        chk("rst_start", 0, alu_start, 0);
        chk("rst_busy", 0, alu_busy, 0);

        run_vecs(0, t1_end);
        chk("t1_starts", 0, m_starts, 1);
        chk("t1_alu_op", 0, m_op, ALU_ADD);
        chk("t1_alu_a", 0, m_a, 123);
        chk("t1_alu_b", 0, m_b, 45);
        run_vecs(t1_end, t2_end);
        chk("t2_alu_op", 0, m_op, ALU_MUL);
        chk("t2_alu_a", 0, m_a, 3);
        chk("t2_alu_a_neg", 0, m_a_neg, 1);
        chk("t2_alu_b", 0, m_b, 2);
        run_vecs(t2_end, vecs.size());

        // Case 5: CLR while the ALU is running.
        press(1, OP_CLR); press(0, 4'd1); press(1, OP_ADD); press(0, 4'd2);
        s0 = m_starts;
        @(negedge clk);
        key_valid = 1'b1; key_is_oper = 1'b1; key_code = OP_EQ;
        @(posedge clk); #1;
        chk("start_latency", 0, alu_start, 1);
        @(negedge clk);
        key_valid = 1'b0; key_is_oper = 1'b0; key_code = 4'd0;
        @(posedge clk); #1;
        chk("start_width", 0, alu_start, 0);
        chk("busy_after_start", 0, alu_busy, 1);
        press(1, OP_CLR);
        repeat (12) @(negedge clk);
        chk("drain_disp_val", 0, disp_val, 0);
        chk("drain_disp_neg", 0, disp_neg, 0);
        chk("drain_error", 0, error, 0);
        chk("drain_busy", 0, alu_busy, 0);
        chk("drain_starts", 0, m_starts, s0 + 1);
        press(0, 4'd6); settle();
        chk("drain_enter_a", 0, disp_val, 6);
        press(1, OP_ADD); settle();
        chk("drain_op", 0, op_latched, OP_ADD);

        // Case 6: operator chaining, then ALU timeout.
        press(1, OP_CLR);
        press(0, 4'd2); press(1, OP_ADD); press(0, 4'd3); press(1, OP_MUL);
        settle();
        chk("chain_disp", 0, disp_val, 5);
        chk("chain_op", 0, op_latched, OP_MUL);
        chk("chain_alu_op", 0, m_op, ALU_ADD);
        chk("chain_alu_a", 0, m_a, 2);
        chk("chain_alu_b", 0, m_b, 3);
        press(0, 4'd4); settle();
        chk("chain_b", 0, disp_val, 4);
        press(1, OP_EQ); settle();
        chk("chain_result", 0, disp_val, 20);
        chk("chain_mul_a", 0, m_a, 5);
        chk("chain_mul_b", 0, m_b, 4);
        m_respond = 1'b0;
        press(1, OP_EQ);
        n = 0;
        while (!error && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_error", 0, error, 1);
        chk("tmo_window", n, (n >= 250 && n <= 262) ? 1 : 0, 1);
        chk("tmo_busy", 0, alu_busy, 0);
        press(0, 4'd5); settle();
        chk("err_ignores_digit", 0, error, 1);

        // Reset mid-ALU; the stray done must not reach the display.
        m_respond = 1'b1;
        press(1, OP_CLR);
        chk("clr_after_tmo", 0, error, 0);
        press(0, 4'd1); press(1, OP_ADD); press(0, 4'd1); press(1, OP_EQ);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("rstmid_disp", 0, disp_val, 0);
        chk("rstmid_busy", 0, alu_busy, 0);
        chk("rstmid_op", 0, op_latched, 0);
        press(0, 4'd3); settle();
        chk("rstmid_enter", 0, disp_val, 3);
        chk("overlap", 0, m_overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
